// File: rtl/sparc_ffu_frf_arb.sv
// sparc_ffu_frf_arb: arbiter/sequencer for the single R/W port of the FP register file.
// Load fills are buffered in a small FIFO (ldq). FPU writebacks and operand reads share the port with them.
// FRF control/data are driven combinationally, and read returns are tagged two cycles after issue.
// Handshake: fpw_req and rd_req are held by the requester until the matching fpw_gnt/rd_gnt
// pulse; ld_vld is a one-cycle pulse that the LSU only raises while ldq_full is low.
module sparc_ffu_frf_arb #(
   parameter int LDQ_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        rclk,
   input  logic        rst_l,
   input  logic        rst_tri_en,
   input  logic        ld_vld,
   input  logic [6:0]  ld_addr,
   input  logic [1:0]  ld_wen,
   input  logic [77:0] ld_data,
   output logic        ldq_full,
   input  logic        fpw_req,
   input  logic [6:0]  fpw_addr,
   input  logic [1:0]  fpw_wen,
   input  logic [77:0] fpw_data,
   output logic        fpw_gnt,
   input  logic        rd_req,
   input  logic [6:0]  rd_addr1,
   input  logic [6:0]  rd_addr2,
   input  logic        rd_dbl,
   output logic        rd_gnt,
   output logic        rd_data_vld,
   output logic        rd_data_src,
   output logic        ctl_frf_ren,
   output logic [1:0]  ctl_frf_wen,
   output logic [6:0]  ctl_frf_addr,
   output logic [77:0] dp_frf_data,
   output logic        dbg_state     // 1 = RD2, second source issue pending
);

   localparam int PW = (LDQ_DEPTH > 2) ? 2 : 1;
   localparam int CW = 3;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(LDQ_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(LDQ_DEPTH - 1);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

   typedef enum logic {IDLE = 1'b0, RD2 = 1'b1} state_t;
   state_t state_q, state_d;

   logic [6:0]           ldq_addr_q [LDQ_DEPTH];
   logic [1:0]           ldq_wen_q  [LDQ_DEPTH];
   logic [77:0]          ldq_data_q [LDQ_DEPTH];
   logic [LDQ_DEPTH-1:0] ldq_vld_q, ldq_vld_d;
   logic [PW-1:0]        ldq_wptr_q, ldq_wptr_d;
   logic [PW-1:0]        ldq_rptr_q, ldq_rptr_d;
   logic [CW-1:0]        ldq_cnt_q, ldq_cnt_d;
   logic [SW-1:0]        starve_q, starve_d;
   logic [6:0]           rd_addr2_q, rd_addr2_d;
   logic                 ret1_vld_q, ret1_src_q, ret2_vld_q, ret2_src_q;

   logic ldq_is_full, ldq_is_empty, ldq_push, ldq_pop;
   logic rd_hazard, rd_elig;
   logic sel_ldq, sel_fpw, sel_rd1, sel_rd2;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign ldq_is_full  = (ldq_cnt_q == DEPTH_C);
   assign ldq_is_empty = (ldq_cnt_q == '0);
   // A fill arriving while full is a protocol error and is dropped.
   assign ldq_push     = rst_l & ld_vld & ~ldq_is_full;
   assign ldq_pop      = sel_ldq;

   // Read hazard: a source address still has a pending write in the ldq or from the FPU.
   always_comb begin
      rd_hazard = 1'b0;
      for (int i = 0; i < LDQ_DEPTH; i++) begin
         if (ldq_vld_q[i] && ((ldq_addr_q[i] == rd_addr1) ||
                              (rd_dbl && (ldq_addr_q[i] == rd_addr2)))) begin
            rd_hazard = 1'b1;
         end
      end
      if (fpw_req && ((fpw_addr == rd_addr1) || (rd_dbl && (fpw_addr == rd_addr2)))) begin
         rd_hazard = 1'b1;
      end
   end

   assign rd_elig = rd_req & ~rd_hazard;

   // Port arbitration: RD2 owns the port outright, IDLE picks the first eligible source.
   always_comb begin
      sel_ldq = 1'b0;
      sel_fpw = 1'b0;
      sel_rd1 = 1'b0;
      sel_rd2 = 1'b0;
      if (rst_l) begin
         if (state_q == RD2) begin
            sel_rd2 = 1'b1;
         end else if (!rst_tri_en) begin
            if (ldq_is_full)                         sel_ldq = 1'b1;
            else if ((starve_q >= STARVE_C) && rd_elig) sel_rd1 = 1'b1;
            else if (!ldq_is_empty)                  sel_ldq = 1'b1;
            else if (fpw_req)                        sel_fpw = 1'b1;
            else if (rd_elig)                        sel_rd1 = 1'b1;
         end
      end
   end

   // FRF port drive: a single op per cycle, all zero when idle.
   always_comb begin
      ctl_frf_ren  = sel_rd1 | sel_rd2;
      ctl_frf_wen  = '0;
      ctl_frf_addr = '0;
      dp_frf_data  = '0;
      if (sel_ldq) begin
         ctl_frf_wen  = ldq_wen_q[ldq_rptr_q];
         ctl_frf_addr = ldq_addr_q[ldq_rptr_q];
         dp_frf_data  = ldq_data_q[ldq_rptr_q];
      end else if (sel_fpw) begin
         ctl_frf_wen  = fpw_wen;
         ctl_frf_addr = fpw_addr;
         dp_frf_data  = fpw_data;
      end else if (sel_rd1) begin
         ctl_frf_addr = rd_addr1;
      end else if (sel_rd2) begin
         ctl_frf_addr = rd_addr2_q;
      end
   end

   assign fpw_gnt     = sel_fpw;
   assign rd_gnt      = (sel_rd1 & ~rd_dbl) | sel_rd2;
   assign ldq_full    = ldq_is_full & rst_l;
   assign rd_data_vld = ret2_vld_q & rst_l;
   assign rd_data_src = ret2_src_q & rst_l;
   assign dbg_state   = (state_q == RD2) & rst_l;

   // Next-state for ldq bookkeeping, FSM, starvation counter and latched second source.
   always_comb begin
      ldq_vld_d  = ldq_vld_q;
      ldq_wptr_d = ldq_wptr_q;
      ldq_rptr_d = ldq_rptr_q;
      ldq_cnt_d  = ldq_cnt_q;
      if (ldq_push) begin
         ldq_vld_d[ldq_wptr_q] = 1'b1;
         ldq_wptr_d            = ptr_inc(ldq_wptr_q);
      end
      if (ldq_pop) begin
         ldq_vld_d[ldq_rptr_q] = 1'b0;
         ldq_rptr_d            = ptr_inc(ldq_rptr_q);
      end
      if (ldq_push && !ldq_pop)      ldq_cnt_d = ldq_cnt_q + 1'b1;
      else if (!ldq_push && ldq_pop) ldq_cnt_d = ldq_cnt_q - 1'b1;

      state_d = state_q;
      if (sel_rd1 && rd_dbl) state_d = RD2;
      else if (sel_rd2)      state_d = IDLE;

      starve_d = starve_q;
      if (!rd_req || rd_gnt)        starve_d = '0;
      else if (starve_q < STARVE_C) starve_d = starve_q + 1'b1;

      rd_addr2_d = sel_rd1 ? rd_addr2 : rd_addr2_q;
   end

   // Control state with synchronous active-low reset; return pipe tags each issued read.
   always_ff @(posedge rclk) begin
      if (!rst_l) begin
         state_q    <= IDLE;
         ldq_vld_q  <= '0;
         ldq_wptr_q <= '0;
         ldq_rptr_q <= '0;
         ldq_cnt_q  <= '0;
         starve_q   <= '0;
         rd_addr2_q <= '0;
         ret1_vld_q <= 1'b0;
         ret1_src_q <= 1'b0;
         ret2_vld_q <= 1'b0;
         ret2_src_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ldq_vld_q  <= ldq_vld_d;
         ldq_wptr_q <= ldq_wptr_d;
         ldq_rptr_q <= ldq_rptr_d;
         ldq_cnt_q  <= ldq_cnt_d;
         starve_q   <= starve_d;
         rd_addr2_q <= rd_addr2_d;
         ret1_vld_q <= sel_rd1 | sel_rd2;
         ret1_src_q <= sel_rd2;
         ret2_vld_q <= ret1_vld_q;
         ret2_src_q <= ret1_src_q;
      end
   end

   // ldq payload storage; validity lives in ldq_vld_q so no reset is needed here.
   always_ff @(posedge rclk) begin
      if (ldq_push) begin
         ldq_addr_q[ldq_wptr_q] <= ld_addr;
         ldq_wen_q[ldq_wptr_q]  <= ld_wen;
         ldq_data_q[ldq_wptr_q] <= ld_data;
      end
   end

endmodule

// File: tb/tb_sparc_ffu_frf_arb.sv
// Directed bench for sparc_ffu_frf_arb: expected port ops and read returns are queued with
// the cycle they must appear in, and a negedge monitor pops and compares them.
module tb_sparc_ffu_frf_arb;

   localparam int OPW  = 16 + 88;
   localparam int RETW = 17;

   logic        rclk = 1'b0;
   logic        rst_l, rst_tri_en;
   logic        ld_vld;
   logic [6:0]  ld_addr;
   logic [1:0]  ld_wen;
   logic [77:0] ld_data;
   logic        ldq_full;
   logic        fpw_req;
   logic [6:0]  fpw_addr;
   logic [1:0]  fpw_wen;
   logic [77:0] fpw_data;
   logic        fpw_gnt;
   logic        rd_req;
   logic [6:0]  rd_addr1, rd_addr2;
   logic        rd_dbl;
   logic        rd_gnt, rd_data_vld, rd_data_src;
   logic        ctl_frf_ren;
   logic [1:0]  ctl_frf_wen;
   logic [6:0]  ctl_frf_addr;
   logic [77:0] dp_frf_data;
   logic        dbg_state;

   logic [OPW-1:0]  exp_q[$];
   logic [RETW-1:0] ret_q[$];
   logic [OPW-1:0]  mon_op;
   logic [RETW-1:0] mon_ret;
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   sparc_ffu_frf_arb #(.LDQ_DEPTH(2), .STARVE_MAX(4)) dut (
      .rclk(rclk), .rst_l(rst_l), .rst_tri_en(rst_tri_en),
      .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_wen(ld_wen), .ld_data(ld_data),
      .ldq_full(ldq_full),
      .fpw_req(fpw_req), .fpw_addr(fpw_addr), .fpw_wen(fpw_wen), .fpw_data(fpw_data),
      .fpw_gnt(fpw_gnt),
      .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_dbl(rd_dbl),
      .rd_gnt(rd_gnt), .rd_data_vld(rd_data_vld), .rd_data_src(rd_data_src),
      .ctl_frf_ren(ctl_frf_ren), .ctl_frf_wen(ctl_frf_wen), .ctl_frf_addr(ctl_frf_addr),
      .dp_frf_data(dp_frf_data), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 rclk = ~rclk;
   always @(posedge rclk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge rclk);
      #1;
   endtask

   task automatic mid();
      @(negedge rclk);
   endtask

   task automatic exp_op(input int c, input logic ren, input logic [1:0] wen,
                         input logic [6:0] a, input logic [77:0] d);
      exp_q.push_back({16'(c), ren, wen, a, d});
   endtask

   task automatic exp_ret(input int c, input logic src);
      ret_q.push_back({16'(c), src});
   endtask

   function automatic logic [77:0] rand78();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[77:0];
   endfunction

   task automatic clear_inputs();
      ld_vld = 1'b0; ld_addr = '0; ld_wen = '0; ld_data = '0;
      fpw_req = 1'b0; fpw_addr = '0; fpw_wen = '0; fpw_data = '0;
      rd_req = 1'b0; rd_addr1 = '0; rd_addr2 = '0; rd_dbl = 1'b0;
   endtask

   // monitor: port ops and read returns against the expected queues, plus invariants
   always @(negedge rclk) begin
      chk("excl_ren_wen", ctl_frf_ren & (|ctl_frf_wen), 1'b0);
      chk("excl_gnt", fpw_gnt & rd_gnt, 1'b0);
      if (ctl_frf_ren || (ctl_frf_wen != 2'b00)) begin
         chk("op_expected", (exp_q.size() != 0), 1'b1);
         if (exp_q.size() != 0) begin
            mon_op = exp_q.pop_front();
            chk("port_op", {cyc[15:0], ctl_frf_ren, ctl_frf_wen, ctl_frf_addr, dp_frf_data}, mon_op);
         end
      end else begin
         chk("idle_zero", {ctl_frf_addr, dp_frf_data}, 0);
      end
      if (rd_data_vld) begin
         chk("ret_expected", (ret_q.size() != 0), 1'b1);
         if (ret_q.size() != 0) begin
            mon_ret = ret_q.pop_front();
            chk("rd_return", {cyc[15:0], rd_data_src}, mon_ret);
         end
      end
   end

   initial begin
      logic [77:0] d, d2;
      rst_l = 1'b0; rst_tri_en = 1'b0;
      clear_inputs();
      nxt(); nxt();
      mid();
      chk("reset_outputs", {ctl_frf_ren, ctl_frf_wen, ctl_frf_addr, dp_frf_data, fpw_gnt,
                            rd_gnt, rd_data_vld, rd_data_src, ldq_full, dbg_state}, 0);
      nxt();
      rst_l = 1'b1;

      // T1: single load fill drains next cycle
      d = rand78();
      ld_vld = 1'b1; ld_addr = 7'h05; ld_wen = 2'b11; ld_data = d;
      exp_op(cyc + 1, 1'b0, 2'b11, 7'h05, d);
      mid(); chk("t1_no_op_on_push", {ctl_frf_ren, ctl_frf_wen}, 0);
      nxt(); ld_vld = 1'b0;
      mid(); chk("t1_wen", ctl_frf_wen, 2'b11); chk("t1_ldq_full", ldq_full, 1'b0);
      nxt();
      mid(); chk("t1_ldq_emptied", ctl_frf_wen, 2'b00);
      nxt();

      // T2: double-source read and tagged returns
      rd_req = 1'b1; rd_dbl = 1'b1; rd_addr1 = 7'h10; rd_addr2 = 7'h11;
      exp_op(cyc, 1'b1, 2'b00, 7'h10, '0);
      exp_op(cyc + 1, 1'b1, 2'b00, 7'h11, '0);
      exp_ret(cyc + 2, 1'b0); exp_ret(cyc + 3, 1'b1);
      mid(); chk("t2_gnt_a1", rd_gnt, 1'b0); chk("t2_ren_a1", ctl_frf_ren, 1'b1);
      nxt();
      mid(); chk("t2_gnt_a2", rd_gnt, 1'b1); chk("t2_state_rd2", dbg_state, 1'b1);
      nxt(); rd_req = 1'b0; rd_dbl = 1'b0;
      mid(); chk("t2_ret_src0", {rd_data_vld, rd_data_src}, 2'b10);
      nxt();
      mid(); chk("t2_ret_src1", {rd_data_vld, rd_data_src}, 2'b11);
      nxt();
      mid(); chk("t2_ret_off", rd_data_vld, 1'b0);
      nxt();

      // T3: fpw wins 4 cycles, starved read wins the 5th, counter then cleared
      fpw_req = 1'b1; fpw_addr = 7'h30; fpw_wen = 2'b01;
      rd_req = 1'b1; rd_dbl = 1'b0; rd_addr1 = 7'h31; rd_addr2 = 7'h31;
      for (int i = 0; i < 4; i++) begin
         d = rand78(); fpw_data = d;
         exp_op(cyc, 1'b0, 2'b01, 7'h30, d);
         mid(); chk("t3_fpw_first", {fpw_gnt, rd_gnt}, 2'b10);
         nxt();
      end
      fpw_data = rand78();
      exp_op(cyc, 1'b1, 2'b00, 7'h31, '0); exp_ret(cyc + 2, 1'b0);
      mid(); chk("t3_rd_after_starve", {fpw_gnt, rd_gnt}, 2'b01);
      nxt();
      d = rand78(); fpw_data = d;
      exp_op(cyc, 1'b0, 2'b01, 7'h30, d);
      mid(); chk("t3_starve_cleared", {fpw_gnt, rd_gnt}, 2'b10);
      nxt(); fpw_req = 1'b0; rd_req = 1'b0;

      // T4: ldq write to the read address issues before the read
      d = rand78();
      ld_vld = 1'b1; ld_addr = 7'h20; ld_wen = 2'b10; ld_data = d;
      exp_op(cyc + 1, 1'b0, 2'b10, 7'h20, d);
      mid();
      nxt(); ld_vld = 1'b0; rd_req = 1'b1; rd_addr1 = 7'h20; rd_addr2 = 7'h00; rd_dbl = 1'b0;
      exp_op(cyc + 1, 1'b1, 2'b00, 7'h20, '0); exp_ret(cyc + 3, 1'b0);
      mid(); chk("t4_rd_blocked", {rd_gnt, ctl_frf_ren}, 2'b00);
      nxt();
      mid(); chk("t4_rd_after_write", rd_gnt, 1'b1);
      nxt(); rd_req = 1'b0;

      // T4b: hazard on second source against a pending fpw keeps the read out past starvation
      fpw_req = 1'b1; fpw_addr = 7'h41; fpw_wen = 2'b11;
      rd_req = 1'b1; rd_dbl = 1'b1; rd_addr1 = 7'h40; rd_addr2 = 7'h41;
      for (int i = 0; i < 6; i++) begin
         d = rand78(); fpw_data = d;
         exp_op(cyc, 1'b0, 2'b11, 7'h41, d);
         mid(); chk("t4b_hazard_blocks_rd", {fpw_gnt, rd_gnt, ctl_frf_ren}, 3'b100);
         nxt();
      end
      fpw_req = 1'b0;
      exp_op(cyc, 1'b1, 2'b00, 7'h40, '0); exp_op(cyc + 1, 1'b1, 2'b00, 7'h41, '0);
      exp_ret(cyc + 2, 1'b0); exp_ret(cyc + 3, 1'b1);
      mid(); chk("t4b_rd_a1", ctl_frf_ren, 1'b1);
      nxt();
      mid(); chk("t4b_rd_gnt", rd_gnt, 1'b1);
      nxt(); rd_req = 1'b0; rd_dbl = 1'b0;

      // rst_tri_en blocks grants while the starve counter keeps advancing
      rst_tri_en = 1'b1;
      rd_req = 1'b1; rd_dbl = 1'b0; rd_addr1 = 7'h70;
      d = rand78();
      fpw_req = 1'b1; fpw_addr = 7'h71; fpw_wen = 2'b01; fpw_data = d;
      for (int i = 0; i < 4; i++) begin
         mid(); chk("tri_no_grant", {fpw_gnt, rd_gnt, ctl_frf_ren, ctl_frf_wen}, 0);
         nxt();
      end
      rst_tri_en = 1'b0;
      exp_op(cyc, 1'b1, 2'b00, 7'h70, '0); exp_ret(cyc + 2, 1'b0);
      mid(); chk("tri_starved_rd_first", {fpw_gnt, rd_gnt}, 2'b01);
      nxt(); rd_req = 1'b0;
      exp_op(cyc, 1'b0, 2'b01, 7'h71, d);
      mid(); chk("tri_fpw_next", fpw_gnt, 1'b1);
      nxt(); fpw_req = 1'b0;

      // ldq overflow: third fill while full is dropped
      rst_tri_en = 1'b1;
      d = rand78(); d2 = rand78();
      ld_vld = 1'b1; ld_addr = 7'h01; ld_wen = 2'b01; ld_data = d;
      mid(); chk("ovf_full_0", ldq_full, 1'b0);
      nxt(); ld_addr = 7'h02; ld_wen = 2'b10; ld_data = d2;
      mid(); chk("ovf_full_1", ldq_full, 1'b0);
      nxt(); ld_addr = 7'h03; ld_wen = 2'b11; ld_data = rand78();
      mid(); chk("ovf_full_2", ldq_full, 1'b1);
      nxt(); ld_vld = 1'b0; rst_tri_en = 1'b0;
      exp_op(cyc, 1'b0, 2'b01, 7'h01, d); exp_op(cyc + 1, 1'b0, 2'b10, 7'h02, d2);
      mid(); chk("ovf_full_3", ldq_full, 1'b1);
      nxt();
      mid(); chk("ovf_full_4", ldq_full, 1'b0);
      nxt();
      mid(); chk("ovf_dropped", ctl_frf_wen, 2'b00);
      nxt();

      // T5: two fills during an RD2 sequence drain afterwards in order
      d = rand78(); d2 = rand78();
      rd_req = 1'b1; rd_dbl = 1'b1; rd_addr1 = 7'h50; rd_addr2 = 7'h51;
      ld_vld = 1'b1; ld_addr = 7'h60; ld_wen = 2'b01; ld_data = d;
      exp_op(cyc, 1'b1, 2'b00, 7'h50, '0); exp_op(cyc + 1, 1'b1, 2'b00, 7'h51, '0);
      exp_op(cyc + 2, 1'b0, 2'b01, 7'h60, d); exp_op(cyc + 3, 1'b0, 2'b11, 7'h61, d2);
      exp_ret(cyc + 2, 1'b0); exp_ret(cyc + 3, 1'b1);
      mid(); chk("t5_full_r0", ldq_full, 1'b0);
      nxt(); ld_addr = 7'h61; ld_wen = 2'b11; ld_data = d2;
      mid(); chk("t5_rd2_gnt", rd_gnt, 1'b1); chk("t5_full_r1", ldq_full, 1'b0);
      nxt(); ld_vld = 1'b0; rd_req = 1'b0; rd_dbl = 1'b0;
      mid(); chk("t5_full_r2", ldq_full, 1'b1);
      nxt();
      mid(); chk("t5_full_r3", ldq_full, 1'b0);
      nxt();
      mid(); chk("t5_drained", ctl_frf_wen, 2'b00);
      nxt();

      // T6: reset right after the first source of a double read
      rd_req = 1'b1; rd_dbl = 1'b1; rd_addr1 = 7'h12; rd_addr2 = 7'h13;
      exp_op(cyc, 1'b1, 2'b00, 7'h12, '0);
      mid();
      nxt(); rst_l = 1'b0;
      mid();
      chk("t6_reset_outputs", {ctl_frf_ren, ctl_frf_wen, ctl_frf_addr, dp_frf_data, fpw_gnt,
                               rd_gnt, rd_data_vld, rd_data_src, ldq_full, dbg_state}, 0);
      nxt(); rst_l = 1'b1; rd_req = 1'b0; rd_dbl = 1'b0;
      mid(); chk("t6_ret_dropped", {rd_data_vld, dbg_state, ctl_frf_ren}, 3'b000);
      nxt();
      mid(); chk("t6_ret_dropped_late", rd_data_vld, 1'b0);
      nxt(); nxt();

      chk("exp_q_drained", exp_q.size(), 0);
      chk("ret_q_drained", ret_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
